// File: rtl/btn_pkg.sv
// Shared constants for the push-button up/down counter.
package btn_pkg;

  // Width of the displayed count (one bit per LED).
  localparam int unsigned CNT_W = 8;

  // Default prescaler width: one debounce sample every 2^N clocks.
  localparam int unsigned N_DEFAULT = 16;

  // Default number of consecutive disagreeing samples before a level flips.
  localparam int unsigned DB_DEFAULT = 4;

  // Width of the per-button agreement counter; DB must fit (1..15).
  localparam int unsigned DB_CNT_W = 4;

endpackage

// File: rtl/debouncer.sv
// Per-button conditioning: 2-FF synchronizer, tick-sampled debouncer and a
// rising-edge detector producing a single-cycle press pulse.
module debouncer
  import btn_pkg::*;
#(
  parameter int unsigned DB = DB_DEFAULT
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic tick,
  input  logic in,
  output logic out,
  output logic rise
);

  localparam logic [DB_CNT_W-1:0] DbLim = DB_CNT_W'(DB);

  logic [1:0]          r_sync;
  logic                r_stable;
  logic [DB_CNT_W-1:0] r_agree;
  logic                r_prev;

  logic                w_synced;
  logic                w_stable_nxt;
  logic [DB_CNT_W-1:0] w_agree_nxt;

  assign w_synced = r_sync[1];

  // Two-flop synchronizer for the raw, asynchronous button input.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], in};
    end
  end

  // Next-state for the debounced level and its agreement counter.
  always_comb begin
    w_stable_nxt = r_stable;
    w_agree_nxt  = r_agree;
    if (tick) begin
      if (w_synced == r_stable) begin
        // Any agreeing sample restarts the count, so short glitches cannot accumulate.
        w_agree_nxt = '0;
      end else if (r_agree + 1'b1 == DbLim) begin
        w_stable_nxt = ~r_stable;
        w_agree_nxt  = '0;
      end else begin
        w_agree_nxt = r_agree + 1'b1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_stable <= 1'b0;
      r_agree  <= '0;
    end else begin
      r_stable <= w_stable_nxt;
      r_agree  <= w_agree_nxt;
    end
  end

  // Delayed copy of the stable level for edge detection.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_stable;
    end
  end

  assign out  = r_stable;
  // Press only; a release (1 -> 0) gives no pulse.
  assign rise = r_stable & ~r_prev;

endmodule

// File: rtl/button_counter.sv
// 8-bit up/down counter stepped by debounced presses of SW1 (up) and SW2 (down),
// shown on LED7..LED0.
module button_counter
  import btn_pkg::*;
#(
  parameter int unsigned N  = N_DEFAULT,
  parameter int unsigned DB = DB_DEFAULT
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic SW1,
  input  logic SW2,
  output logic LED0,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic LED6,
  output logic LED7
);

  logic [N-1:0]     r_presc;
  logic [CNT_W-1:0] r_count;

  logic             w_tick;
  logic             w_up_level;
  logic             w_up_rise;
  logic             w_dn_level;
  logic             w_dn_rise;
  logic             w_up_step;
  logic             w_dn_step;
  logic [CNT_W-1:0] w_count_nxt;

  // Free-running prescaler; wraps from 2^N-1 to 0 on its own.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick = &r_presc;

  debouncer #(
    .DB (DB)
  ) u_up (
    .CLK  (CLK),
    .RSTN (RSTN),
    .tick (w_tick),
    .in   (SW1),
    .out  (w_up_level),
    .rise (w_up_rise)
  );

  debouncer #(
    .DB (DB)
  ) u_dn (
    .CLK  (CLK),
    .RSTN (RSTN),
    .tick (w_tick),
    .in   (SW2),
    .out  (w_dn_level),
    .rise (w_dn_rise)
  );

  // A press pulse always coincides with a high level; qualifying keeps that explicit.
  assign w_up_step = w_up_rise & w_up_level;
  assign w_dn_step = w_dn_rise & w_dn_level;

  // Count next-state: simultaneous up and down presses cancel.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_up_step, w_dn_step})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Count register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_nxt;
    end
  end

  assign {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0} = r_count;

endmodule

// File: tb/tb_button_counter.sv
// Scoreboard bench for button_counter with N=2 (tick every 4 clocks), DB=3.
module tb_button_counter;

  localparam int unsigned N  = 2;
  localparam int unsigned DB = 3;
  // Allowed press-to-LED latency window in clocks.
  localparam int LatMin = 12;
  localparam int LatMax = 19;

  logic CLK  = 1'b0;
  logic RSTN = 1'b1;
  logic SW1  = 1'b0;
  logic SW2  = 1'b0;
  logic LED0, LED1, LED2, LED3, LED4, LED5, LED6, LED7;
  logic [7:0] leds;

  assign leds = {LED7, LED6, LED5, LED4, LED3, LED2, LED1, LED0};

  button_counter #(
    .N  (N),
    .DB (DB)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .SW1  (SW1),
    .SW2  (SW2),
    .LED0 (LED0),
    .LED1 (LED1),
    .LED2 (LED2),
    .LED3 (LED3),
    .LED4 (LED4),
    .LED5 (LED5),
    .LED6 (LED6),
    .LED7 (LED7)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  val;
    int unsigned t0;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_cnt = 8'h00;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic void check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: every LED change must match the next queued step, within the latency window.
  logic [7:0] last_led = 8'h00;
  exp_t       mon_e;
  int         mon_dt;
  always @(negedge CLK) begin
    if (!RSTN) begin
      last_led = 8'h00;
    end else if (leds != last_led) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: actual %0d required %0d (t=%0t)", leds, last_led, $time);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_dt = int'(cyc) - int'(mon_e.t0);
        check("step_value", int'(leds), int'(mon_e.val));
        n_cmp++;
        if (mon_dt < LatMin || mon_dt > LatMax) begin
          n_bad++;
          $display("FAIL step_latency: actual %0d required %0d..%0d", mon_dt, LatMin, LatMax);
        end
      end
      last_led = leds;
    end
  end

  // Press-pulse observer used for the simultaneous-press scenario.
  int n_coinc  = 0;
  int n_single = 0;
  always @(negedge CLK) begin
    if (RSTN) begin
      if (dut.w_up_rise && dut.w_dn_rise) n_coinc++;
      else if (dut.w_up_rise || dut.w_dn_rise) n_single++;
    end
  end

  task automatic clocks(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold >= 20 clocks is a clean press; hold <= 6 clocks is a rejected glitch.
  task automatic press(bit up, bit dn, int hold, int gap);
    exp_t e;
    SW1 = up;
    SW2 = dn;
    if (hold >= 20 && (up ^ dn)) begin
      model_cnt = up ? model_cnt + 8'd1 : model_cnt - 8'd1;
      e.val = model_cnt;
      e.t0  = cyc;
      exp_q.push_back(e);
    end
    clocks(hold);
    SW1 = 1'b0;
    SW2 = 1'b0;
    clocks(gap);
  endtask

  task automatic do_reset(int len);
    RSTN = 1'b0;
    exp_q.delete();
    model_cnt = 8'h00;
    clocks(len);
    RSTN = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, s0, sel, wait_n;
    exp_t e;

    // Reset and idle.
    #2;
    RSTN = 1'b0;
    #1;
    check("reset_leds", int'(leds), 0);
    clocks(3);
    RSTN = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clocks(10);
      check("idle_leds", int'(leds), 0);
    end

    // One clean SW1 press.
    press(1'b1, 1'b0, 40, 40);
    check("single_press", int'(leds), 1);

    // Short pulses never step the count.
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 5, 20);
    check("glitch_reject", int'(leds), 1);

    // Asynchronous reset mid-cycle clears LEDs without a clock edge.
    @(posedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("async_reset", int'(leds), 0);
    exp_q.delete();
    model_cnt = 8'h00;
    clocks(2);
    RSTN = 1'b1;
    clocks(10);

    // 256 presses wrap back to zero, then one down press gives 0xFF.
    for (int i = 0; i < 256; i++) begin
      press(1'b1, 1'b0, 20, 20);
      if (i == 254) check("reach_ff", int'(leds), 255);
    end
    check("wrap_zero", int'(leds), 0);
    press(1'b0, 1'b1, 30, 30);
    check("down_wrap", int'(leds), 255);

    // Simultaneous presses cancel; their pulses must coincide.
    c0 = n_coinc;
    s0 = n_single;
    press(1'b1, 1'b1, 40, 40);
    check("both_leds", int'(leds), 255);
    check("both_coincident", n_coinc - c0, 1);
    check("both_no_single", n_single - s0, 0);

    // Randomized mix of clean presses, glitches and cancelling presses.
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: press(1'b1, 1'b0, int'($urandom_range(20, 40)), int'($urandom_range(20, 35)));
        1: press(1'b0, 1'b1, int'($urandom_range(20, 40)), int'($urandom_range(20, 35)));
        2: press(1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 6)),
                 int'($urandom_range(20, 35)));
        default: press(1'b1, 1'b1, int'($urandom_range(20, 40)), int'($urandom_range(20, 35)));
      endcase
    end
    check("random_leds", int'(leds), int'(model_cnt));

    // Reset after two agreeing ticks loses the press; a held button re-registers.
    SW2 = 1'b1;
    clocks(10);
    do_reset(2);
    check("mid_press_reset", int'(leds), 0);
    model_cnt = 8'hFF;
    e.val = 8'hFF;
    e.t0  = cyc;
    exp_q.push_back(e);
    clocks(30);
    SW2 = 1'b0;
    clocks(30);
    check("reheld_press", int'(leds), 255);

    // Drain outstanding expectations with a bounded wait.
    wait_n = 0;
    while (exp_q.size() != 0 && wait_n < 40) begin
      clocks(1);
      wait_n++;
    end
    check("queue_drained", exp_q.size(), 0);
    check("final_leds", int'(leds), int'(model_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
